// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the TinyMIPS multicycle controller: FSM state codes,
// opcodes and the mux/ALU select encodings driven onto the datapath.
package mc_ctrl_pkg;

    // FSM state encodings (4 bits, also exported on state_o for debug)
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_LBRD    = 4'd3;
    localparam logic [3:0] S_LBWR    = 4'd4;
    localparam logic [3:0] S_SBWR    = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWR = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_JEX     = 4'd9;
    localparam logic [3:0] S_ADDIWR  = 4'd10;
    localparam logic [3:0] S_BNEEX   = 4'd11;

    // Opcode field values
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b100100;
    localparam logic [5:0] OP_J     = 6'b100010;
    localparam logic [5:0] OP_BNE   = 6'b100101;

    // ALU B-operand select
    localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
    localparam logic [1:0] ALUSRCB_ONE   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_BROFF = 2'b11;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Where MEMADR goes once the effective address is formed
    function automatic logic [3:0] memadr_next(input logic [5:0] op);
        case (op)
            OP_LB:   return S_LBRD;
            OP_SB:   return S_SBWR;
            OP_ADDI: return S_ADDIWR;
            default: return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_p_if.sv
// Controller <-> datapath/memory bundle. The controller is the master: it
// consumes the opcode, zero flag and memory ready, and drives every control line.
interface mc_controller_p_if #(
    parameter int FETCH_BEATS = 4
);
    logic [5:0]             op;
    logic                   zero;
    logic                   mem_ready;
    logic                   memread;
    logic                   memwrite;
    logic                   iord;
    logic                   alusrca;
    logic [1:0]             alusrcb;
    logic [1:0]             aluop;
    logic [1:0]             pcsource;
    logic                   pcen;
    logic                   regwrite;
    logic                   regdst;
    logic                   memtoreg;
    logic [FETCH_BEATS-1:0] irwrite;
    logic                   illegal_op;
    logic [3:0]             state_o;

    modport master (
        input  op, zero, mem_ready,
        output memread, memwrite, iord, alusrca, alusrcb, aluop, pcsource,
               pcen, regwrite, regdst, memtoreg, irwrite, illegal_op, state_o
    );

    modport slave (
        output op, zero, mem_ready,
        input  memread, memwrite, iord, alusrca, alusrcb, aluop, pcsource,
               pcen, regwrite, regdst, memtoreg, irwrite, illegal_op, state_o
    );
endinterface

// File: rtl/mc_fetch_seq.sv
// Instruction fetch beat sequencer: counts memory beats while the controller
// sits in FETCH and strobes the matching IR byte lane when a beat completes.
module mc_fetch_seq #(
    parameter int FETCH_BEATS = 4,
    parameter int BEAT_W      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   active,
    input  logic                   mem_ready,
    output logic [BEAT_W-1:0]      beat,
    output logic                   last_beat,
    output logic [FETCH_BEATS-1:0] irwrite
);
    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(FETCH_BEATS - 1);

    logic [BEAT_W-1:0] beat_q, beat_d;

    // Advance on each completed beat, wrap after the last one; outside FETCH the counter parks at 0
    always_comb begin
        beat_d = beat_q;
        if (!active) begin
            beat_d = '0;
        end else if (mem_ready) begin
            beat_d = last_beat ? '0 : beat_q + 1'b1;
        end
    end

    // Beat counter register
    always_ff @(posedge clk) begin
        if (rst) beat_q <= '0;
        else     beat_q <= beat_d;
    end

    // One-hot lane strobe, only on the cycle the memory completes the beat and never under reset
    always_comb begin
        irwrite = '0;
        if (active && mem_ready && !rst) begin
            irwrite = FETCH_BEATS'(1) << beat_q;
        end
    end

    assign beat      = beat_q;
    assign last_beat = (beat_q == LAST);
endmodule

// File: rtl/mc_controller_p.sv
// Parametrised multicycle controller for the TinyMIPS datapath. Fetches an
// instruction over FETCH_BEATS memory beats, then sequences decode / execute /
// writeback per opcode, stretching memory states with mem_ready wait states.
// Optional feature macro: MC_CTRL_BNE_EN (adds BNE, otherwise BNE is illegal).
module mc_controller_p
    import mc_ctrl_pkg::*;
#(
    parameter int FETCH_BEATS = 4
) (
    input  logic              clk,
    input  logic              rst,
    mc_controller_p_if.master bus
);
    localparam int BEAT_W = (FETCH_BEATS == 1) ? 1 : $clog2(FETCH_BEATS);
`ifdef MC_CTRL_BNE_EN
    localparam logic BNE_EN = 1'b1;
`else
    localparam logic BNE_EN = 1'b0;
`endif

    logic [3:0]             state_q, state_d, dec_next;
    logic [BEAT_W-1:0]      fetch_beat_unused;  // beat index is consumed inside the sequencer only
    logic                   last_beat;
    logic [FETCH_BEATS-1:0] irwrite;

    mc_fetch_seq #(
        .FETCH_BEATS(FETCH_BEATS),
        .BEAT_W     (BEAT_W)
    ) u_fetch (
        .clk      (clk),
        .rst      (rst),
        .active   (state_q == S_FETCH),
        .mem_ready(bus.mem_ready),
        .beat     (fetch_beat_unused),
        .last_beat(last_beat),
        .irwrite  (irwrite)
    );

    // Opcode dispatch out of DECODE; S_FETCH here means the opcode is illegal
    always_comb begin
        dec_next = S_FETCH;
        case (bus.op)
            OP_LB, OP_SB, OP_ADDI: dec_next = S_MEMADR;
            OP_RTYPE:              dec_next = S_RTYPEEX;
            OP_BEQ:                dec_next = S_BEQEX;
            OP_J:                  dec_next = S_JEX;
            OP_BNE:                dec_next = BNE_EN ? S_BNEEX : S_FETCH;
            default:               dec_next = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state logic; unknown encodings recover to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = (bus.mem_ready && last_beat) ? S_DECODE : S_FETCH;
            S_DECODE:  state_d = dec_next;
            S_MEMADR:  state_d = memadr_next(bus.op);
            S_LBRD:    state_d = bus.mem_ready ? S_LBWR : S_LBRD;
            S_SBWR:    state_d = bus.mem_ready ? S_FETCH : S_SBWR;
            S_RTYPEEX: state_d = S_RTYPEWR;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore output decode from state (plus mem_ready/zero where the state qualifies them)
    always_comb begin
        bus.memread    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.iord       = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = ALUSRCB_REGB;
        bus.aluop      = ALUOP_ADD;
        bus.pcsource   = PCSRC_ALU;
        bus.pcen       = 1'b0;
        bus.regwrite   = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.memread  = 1'b1;
                bus.alusrcb  = ALUSRCB_ONE;
                bus.pcsource = PCSRC_ALU;
                bus.pcen     = bus.mem_ready && !rst;
            end
            S_DECODE: begin
                bus.alusrcb    = ALUSRCB_BROFF;
                bus.aluop      = ALUOP_ADD;
                bus.illegal_op = (dec_next == S_FETCH);
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = ALUSRCB_IMM;
                bus.aluop   = ALUOP_ADD;
            end
            S_LBRD: begin
                bus.memread = 1'b1;
                bus.iord    = 1'b1;
            end
            S_LBWR: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
            end
            S_SBWR: begin
                bus.memwrite = 1'b1;
                bus.iord     = 1'b1;
            end
            S_RTYPEEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = ALUSRCB_REGB;
                bus.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWR: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
            end
            S_ADDIWR: begin
                bus.regwrite = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                bus.alusrca  = 1'b1;
                bus.alusrcb  = ALUSRCB_REGB;
                bus.aluop    = ALUOP_SUB;
                bus.pcsource = PCSRC_ALUOUT;
                bus.pcen     = (state_q == S_BEQEX) ? bus.zero : !bus.zero;
            end
            S_JEX: begin
                bus.pcsource = PCSRC_JUMP;
                bus.pcen     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.irwrite = irwrite;
    assign bus.state_o = state_q;
endmodule

// File: tb/tb_mc_controller_p.sv
// Bench for mc_controller_p: three instances (FETCH_BEATS = 4, 1, 2) driven by
// instruction-level stimulus; each instruction expands into the cycle-by-cycle
// control vector it must produce, which one compare process checks.
module tb_mc_controller_p;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       pcen;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic [7:0] irwrite;
        logic       illegal_op;
    } vec_t;

    localparam logic [5:0] T_R = 6'b000000, T_LB = 6'b100000, T_SB = 6'b101000, T_ADDI = 6'b001000;
    localparam logic [5:0] T_BEQ = 6'b100100, T_J = 6'b100010, T_BNE = 6'b100101;

    localparam int C_LB = 0, C_SB = 1, C_ADDI = 2, C_R = 3, C_BEQ = 4, C_BNE = 5, C_J = 6, C_ILL = 7;
    localparam int P_DEC = 0, P_DECILL = 1, P_MEMADR = 2, P_LBRD = 3, P_LBWR = 4, P_SBWR = 5;
    localparam int P_REX = 6, P_RWR = 7, P_ADDIWR = 8, P_BEQ = 9, P_BNE = 10, P_J = 11;

    logic       clk = 1'b0;
    logic       rst_v  [3];
    logic [5:0] op_v   [3];
    logic       zero_v [3];
    logic       mr_v   [3];
    vec_t       got    [3];
    vec_t       exp_v  [3];
    logic       chk    [3];

    logic       lit_on = 1'b0;
    int         lit_k  = 0;
    vec_t       lit_m, lit_v;
    string      lit_nm = "";

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mc_controller_p_if #(.FETCH_BEATS(4)) if0 ();
    mc_controller_p_if #(.FETCH_BEATS(1)) if1 ();
    mc_controller_p_if #(.FETCH_BEATS(2)) if2 ();

    assign if0.op = op_v[0];  assign if0.zero = zero_v[0];  assign if0.mem_ready = mr_v[0];
    assign if1.op = op_v[1];  assign if1.zero = zero_v[1];  assign if1.mem_ready = mr_v[1];
    assign if2.op = op_v[2];  assign if2.zero = zero_v[2];  assign if2.mem_ready = mr_v[2];

    mc_controller_p #(.FETCH_BEATS(4)) u_dut4 (.clk(clk), .rst(rst_v[0]), .bus(if0));
    mc_controller_p #(.FETCH_BEATS(1)) u_dut1 (.clk(clk), .rst(rst_v[1]), .bus(if1));
    mc_controller_p #(.FETCH_BEATS(2)) u_dut2 (.clk(clk), .rst(rst_v[2]), .bus(if2));

    assign got[0] = {if0.memread, if0.memwrite, if0.iord, if0.alusrca, if0.alusrcb, if0.aluop,
                     if0.pcsource, if0.pcen, if0.regwrite, if0.regdst, if0.memtoreg,
                     4'b0, if0.irwrite, if0.illegal_op};
    assign got[1] = {if1.memread, if1.memwrite, if1.iord, if1.alusrca, if1.alusrcb, if1.aluop,
                     if1.pcsource, if1.pcen, if1.regwrite, if1.regdst, if1.memtoreg,
                     7'b0, if1.irwrite, if1.illegal_op};
    assign got[2] = {if2.memread, if2.memwrite, if2.iord, if2.alusrca, if2.alusrcb, if2.aluop,
                     if2.pcsource, if2.pcen, if2.regwrite, if2.regdst, if2.memtoreg,
                     6'b0, if2.irwrite, if2.illegal_op};

    // Single compare process: full model vector per active instance, plus any literal pin
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (chk[k]) begin
                n_chk++;
                if (got[k] !== exp_v[k]) begin
                    n_fail++;
                    $display("FAIL cycle_vec dut%0d t=%0t: got %h required %h", k, $time, got[k], exp_v[k]);
                end
            end
        end
        if (lit_on) begin
            n_chk++;
            if ((got[lit_k] & lit_m) !== lit_v) begin
                n_fail++;
                $display("FAIL %s dut%0d t=%0t: got %h required %h (mask %h)",
                         lit_nm, lit_k, $time, got[lit_k] & lit_m, lit_v, lit_m);
            end
        end
    end

    function automatic int fb_of(int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : 2;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic int cls(logic [5:0] op);
        case (op)
            T_LB:   return C_LB;
            T_SB:   return C_SB;
            T_ADDI: return C_ADDI;
            T_R:    return C_R;
            T_BEQ:  return C_BEQ;
            T_J:    return C_J;
`ifdef MC_CTRL_BNE_EN
            T_BNE:  return C_BNE;
`else
            T_BNE:  return C_ILL;
`endif
            default: return C_ILL;
        endcase
    endfunction

    function automatic vec_t v_fetch(int b, logic mr);
        vec_t v = '0;
        v.memread = 1'b1;
        v.alusrcb = 2'b01;
        v.pcen    = mr;
        if (mr) v.irwrite = 8'(1 << b);
        return v;
    endfunction

    function automatic vec_t vp(int p, logic z);
        vec_t v = '0;
        case (p)
            P_DEC:    v.alusrcb = 2'b11;
            P_DECILL: begin v.alusrcb = 2'b11; v.illegal_op = 1'b1; end
            P_MEMADR: begin v.alusrca = 1'b1; v.alusrcb = 2'b10; end
            P_LBRD:   begin v.memread = 1'b1; v.iord = 1'b1; end
            P_LBWR:   begin v.regwrite = 1'b1; v.memtoreg = 1'b1; end
            P_SBWR:   begin v.memwrite = 1'b1; v.iord = 1'b1; end
            P_REX:    begin v.alusrca = 1'b1; v.aluop = 2'b10; end
            P_RWR:    begin v.regwrite = 1'b1; v.regdst = 1'b1; end
            P_ADDIWR: v.regwrite = 1'b1;
            P_BEQ:    begin v.alusrca = 1'b1; v.aluop = 2'b01; v.pcsource = 2'b01; v.pcen = z; end
            P_BNE:    begin v.alusrca = 1'b1; v.aluop = 2'b01; v.pcsource = 2'b01; v.pcen = !z; end
            P_J:      begin v.pcsource = 2'b10; v.pcen = 1'b1; end
            default:  ;
        endcase
        return v;
    endfunction

    task automatic step(int k, vec_t e, logic mr, logic z, logic [5:0] op);
        @(posedge clk); #1;
        mr_v[k] = mr; zero_v[k] = z; op_v[k] = op;
        exp_v[k] = e; chk[k] = 1'b1; lit_on = 1'b0;
    endtask

    task automatic pin(int k, vec_t m, vec_t v, string nm);
        lit_k = k; lit_m = m; lit_v = v; lit_nm = nm; lit_on = 1'b1;
    endtask

    task automatic pin_irw(int k, logic [7:0] irw, logic pc, string nm);
        vec_t m = '0;
        vec_t v = '0;
        m.irwrite = '1; m.pcen = 1'b1;
        v.irwrite = irw; v.pcen = pc;
        pin(k, m, v, nm);
    endtask

    task automatic fetch_all(int k, int fw);
        for (int b = 0; b < fb_of(k); b++) begin
            int nw = $urandom_range(0, fw);
            repeat (nw) step(k, v_fetch(b, 1'b0), 1'b0, rb(), 6'($urandom));
            step(k, v_fetch(b, 1'b1), 1'b1, rb(), 6'($urandom));
        end
    endtask

    task automatic instr(int k, logic [5:0] op, int fw, int mw);
        logic z;
        int   nw;
        fetch_all(k, fw);
        z = rb();
        step(k, vp((cls(op) == C_ILL) ? P_DECILL : P_DEC, z), rb(), z, op);
        nw = $urandom_range(0, mw);
        case (cls(op))
            C_LB: begin
                step(k, vp(P_MEMADR, z), rb(), z, op);
                repeat (nw) step(k, vp(P_LBRD, z), 1'b0, z, op);
                step(k, vp(P_LBRD, z), 1'b1, z, op);
                step(k, vp(P_LBWR, z), rb(), z, op);
            end
            C_SB: begin
                step(k, vp(P_MEMADR, z), rb(), z, op);
                repeat (nw) step(k, vp(P_SBWR, z), 1'b0, z, op);
                step(k, vp(P_SBWR, z), 1'b1, z, op);
            end
            C_ADDI: begin
                step(k, vp(P_MEMADR, z), rb(), z, op);
                step(k, vp(P_ADDIWR, z), rb(), z, op);
            end
            C_R: begin
                step(k, vp(P_REX, z), rb(), z, op);
                step(k, vp(P_RWR, z), rb(), z, op);
            end
            C_BEQ: step(k, vp(P_BEQ, z), rb(), z, op);
            C_BNE: step(k, vp(P_BNE, z), rb(), z, op);
            C_J:   step(k, vp(P_J, z), rb(), z, op);
            default: ;
        endcase
        step(k, v_fetch(0, 1'b0), 1'b0, z, op);
    endtask

    task automatic branch_dir(int k, logic [5:0] op, logic z, logic pc_lit, string nm);
        vec_t m = '0;
        vec_t v = '0;
        fetch_all(k, 0);
        step(k, vp(P_DEC, z), 1'b0, z, op);
        step(k, vp((op == T_BNE) ? P_BNE : P_BEQ, z), 1'b0, z, op);
        m.pcen = 1'b1; m.pcsource = 2'b11;
        v.pcen = pc_lit; v.pcsource = 2'b01;
        pin(k, m, v, nm);
        step(k, v_fetch(0, 1'b0), 1'b0, z, op);
    endtask

    task automatic sb_reset(int k, logic mr_in_rst);
        vec_t m = '0;
        vec_t v = '0;
        fetch_all(k, 1);
        step(k, vp(P_DEC, 1'b0), 1'b0, 1'b0, T_SB);
        step(k, vp(P_MEMADR, 1'b0), 1'b0, 1'b0, T_SB);
        step(k, vp(P_SBWR, 1'b0), 1'b0, 1'b0, T_SB);
        step(k, vp(P_SBWR, 1'b0), 1'b0, 1'b0, T_SB);
        @(posedge clk); #1;
        rst_v[k] = 1'b1; mr_v[k] = mr_in_rst; lit_on = 1'b0;
        @(posedge clk); #1;
        rst_v[k] = 1'b0; mr_v[k] = 1'b0;
        exp_v[k] = v_fetch(0, 1'b0);
        m.memwrite = 1'b1; m.irwrite = '1; m.memread = 1'b1; m.alusrcb = 2'b11;
        v.memread = 1'b1; v.alusrcb = 2'b01;
        pin(k, m, v, "sb_rst_next");
        instr(k, T_ADDI, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] irw_lit [4];
        vec_t       m, v;
        logic [5:0] ops [8];
        irw_lit = '{8'h01, 8'h02, 8'h04, 8'h08};
        ops     = '{T_R, T_LB, T_SB, T_ADDI, T_BEQ, T_J, T_BNE, 6'b111111};
        for (int k = 0; k < 3; k++) begin
            rst_v[k] = 1'b1; mr_v[k] = 1'b0; zero_v[k] = 1'b0; op_v[k] = '0;
            chk[k] = 1'b0; exp_v[k] = '0;
        end
        lit_m = '0; lit_v = '0;

        // reset state: FETCH beat 0 values while rst is still high
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin exp_v[k] = v_fetch(0, 1'b0); chk[k] = 1'b1; end
        m = '0; m.memread = 1'b1; m.alusrcb = 2'b11; m.pcen = 1'b1; m.irwrite = '1;
        v = '0; v.memread = 1'b1; v.alusrcb = 2'b01;
        pin(0, m, v, "reset_state");
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;

        // ADDI back to back, no waits: lanes 0..3 then DECODE/MEMADR/ADDIWR, FETCH at cycle 7
        for (int b = 0; b < 4; b++) begin
            step(0, v_fetch(b, 1'b1), 1'b1, 1'b0, T_ADDI);
            pin_irw(0, irw_lit[b], 1'b1, "addi_fetch_lane");
        end
        step(0, vp(P_DEC, 1'b0), 1'b0, 1'b0, T_ADDI);
        step(0, vp(P_MEMADR, 1'b0), 1'b0, 1'b0, T_ADDI);
        step(0, vp(P_ADDIWR, 1'b0), 1'b0, 1'b0, T_ADDI);
        m = '0; m.regwrite = 1'b1; m.regdst = 1'b1;
        v = '0; v.regwrite = 1'b1;
        pin(0, m, v, "addiwr_rt");
        step(0, v_fetch(0, 1'b0), 1'b0, 1'b0, T_ADDI);
        m = '0; m.memread = 1'b1; m.regwrite = 1'b1;
        v = '0; v.memread = 1'b1;
        pin(0, m, v, "addi_back_to_fetch");

        // three wait cycles on beat 1: lane 1 strobes once, 7 fetch cycles total
        step(0, v_fetch(0, 1'b1), 1'b1, 1'b0, T_J);
        pin_irw(0, 8'h01, 1'b1, "wait_b0");
        for (int i = 0; i < 3; i++) begin
            step(0, v_fetch(1, 1'b0), 1'b0, 1'b0, T_J);
            pin_irw(0, 8'h00, 1'b0, "wait_b1_hold");
        end
        step(0, v_fetch(1, 1'b1), 1'b1, 1'b0, T_J);
        pin_irw(0, 8'h02, 1'b1, "wait_b1_ready");
        step(0, v_fetch(2, 1'b1), 1'b1, 1'b0, T_J);
        step(0, v_fetch(3, 1'b1), 1'b1, 1'b0, T_J);
        pin_irw(0, 8'h08, 1'b1, "wait_b3");
        step(0, vp(P_DEC, 1'b0), 1'b0, 1'b0, T_J);
        step(0, vp(P_J, 1'b0), 1'b0, 1'b0, T_J);
        step(0, v_fetch(0, 1'b0), 1'b0, 1'b0, T_J);

        // LB with two wait states in LBRD
        fetch_all(0, 0);
        step(0, vp(P_DEC, 1'b0), 1'b0, 1'b0, T_LB);
        step(0, vp(P_MEMADR, 1'b0), 1'b0, 1'b0, T_LB);
        for (int i = 0; i < 3; i++) begin
            step(0, vp(P_LBRD, 1'b0), (i == 2), 1'b0, T_LB);
            m = '0; m.memread = 1'b1; m.iord = 1'b1;
            v = '0; v.memread = 1'b1; v.iord = 1'b1;
            pin(0, m, v, "lbrd_wait");
        end
        step(0, vp(P_LBWR, 1'b0), 1'b0, 1'b0, T_LB);
        m = '0; m.regwrite = 1'b1; m.memtoreg = 1'b1;
        v = '0; v.regwrite = 1'b1; v.memtoreg = 1'b1;
        pin(0, m, v, "lbwr");
        step(0, v_fetch(0, 1'b0), 1'b0, 1'b0, T_LB);

        // branches
        branch_dir(0, T_BEQ, 1'b1, 1'b1, "beq_taken");
        branch_dir(0, T_BEQ, 1'b0, 1'b0, "beq_not_taken");
`ifdef MC_CTRL_BNE_EN
        branch_dir(0, T_BNE, 1'b1, 1'b0, "bne_not_taken");
        branch_dir(0, T_BNE, 1'b0, 1'b1, "bne_taken");
`else
        fetch_all(0, 0);
        step(0, vp(P_DECILL, 1'b0), 1'b0, 1'b0, T_BNE);
        m = '0; m.illegal_op = 1'b1;
        v = '0; v.illegal_op = 1'b1;
        pin(0, m, v, "bne_illegal");
        step(0, v_fetch(0, 1'b0), 1'b0, 1'b0, T_BNE);
`endif

        // illegal opcode 111111
        fetch_all(0, 1);
        step(0, vp(P_DECILL, 1'b0), 1'b0, 1'b0, 6'b111111);
        m = '0; m.illegal_op = 1'b1;
        v = '0; v.illegal_op = 1'b1;
        pin(0, m, v, "illegal_pulse");
        step(0, v_fetch(0, 1'b0), 1'b0, 1'b0, 6'b111111);
        m = '0; m.illegal_op = 1'b1; m.regwrite = 1'b1; m.memwrite = 1'b1; m.memread = 1'b1;
        v = '0; v.memread = 1'b1;
        pin(0, m, v, "illegal_then_fetch");

        // reset during SBWR wait on every beat count
        sb_reset(0, 1'b0);
        sb_reset(1, 1'b1);
        sb_reset(2, 1'b0);

        // randomized instruction mix across all three instances
        repeat (300) begin
            int         k;
            int         r;
            logic [5:0] op;
            k  = $urandom_range(0, 2);
            r  = $urandom_range(0, 9);
            op = (r < 8) ? ops[r] : 6'($urandom);
            instr(k, op, 2, 3);
        end

        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
